// File: rtl/event_reader_if.sv
// Event-reader bus bundle: event FIFO read port plus the outgoing AXI-stream.
// The master side is the event reader; the slave side is the FIFO/stream environment.
interface event_reader_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   empty_i;
  logic [COUNT_WIDTH-1:0] rd_count_i;
  logic [63:0]            dout_i;
  logic                   rd_en_o;
  logic [63:0]            m_axis_tdata;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic                   m_axis_tlast;

  modport master (
    input  empty_i,
    input  rd_count_i,
    input  dout_i,
    input  m_axis_tready,
    output rd_en_o,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast
  );

  modport slave (
    output empty_i,
    output rd_count_i,
    output dout_i,
    output m_axis_tready,
    input  rd_en_o,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast
  );
endinterface

// File: rtl/event_reader.sv
// Event reader: waits until a whole event is in the FIFO, then moves it word by
// word onto an AXI-stream, flagging the last word and counting finished events.
// Optional macro EVENT_HEADER_EN prepends a header beat {"MUON", event count}.
module event_reader #(
  parameter int WORDS_PER_EVENT = 16,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                clk,
  input  logic                reset,
  event_reader_if.master      bus,
  output logic                event_sent_o,
  output logic [31:0]         event_count_o
);

  localparam int CW = (WORDS_PER_EVENT > 1) ? $clog2(WORDS_PER_EVENT) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_EVENT - 1);
  localparam logic [COUNT_WIDTH:0] THRESHOLD = (COUNT_WIDTH + 1)'(WORDS_PER_EVENT);
  localparam logic [31:0] HEADER_MAGIC = 32'h4D554F4E;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    READ,
    LATCH,
    SEND,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] word_cnt;
  logic [63:0]   data_q;
  logic          event_ready;

  // The event is only started once every one of its words is already queued.
  assign event_ready = ({1'b0, bus.rd_count_i} >= THRESHOLD);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; rd_count_i is only consulted in IDLE so mid-event changes do nothing.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (event_ready) begin
`ifdef EVENT_HEADER_EN
          state_next = HEADER;
`else
          state_next = READ;
`endif
        end
      end
      HEADER: begin
        if (bus.m_axis_tready) begin
          state_next = READ;
        end
      end
      READ: begin
        if (!bus.empty_i) begin
          state_next = LATCH;
        end
      end
      LATCH: begin
        state_next = SEND;
      end
      SEND: begin
        if (bus.m_axis_tready) begin
          state_next = (word_cnt == LAST_WORD) ? DONE : READ;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from state; the read strobe is suppressed while reset is high.
  always_comb begin
    bus.rd_en_o       = (state == READ) && !bus.empty_i && !reset;
    bus.m_axis_tvalid = (state == SEND) || (state == HEADER);
    bus.m_axis_tlast  = (state == SEND) && (word_cnt == LAST_WORD);
    bus.m_axis_tdata  = data_q;
    event_sent_o      = (state == DONE);
`ifdef EVENT_HEADER_EN
    if (state == HEADER) begin
      bus.m_axis_tdata = {HEADER_MAGIC, event_count_o};
    end
`endif
  end

  // Datapath: capture FIFO data, advance the word index, count completed events.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt      <= '0;
      data_q        <= '0;
      event_count_o <= '0;
    end else begin
      if (state == LATCH) begin
        data_q <= bus.dout_i;
      end
      if ((state == SEND) && bus.m_axis_tready && (word_cnt != LAST_WORD)) begin
        word_cnt <= word_cnt + CW'(1);
      end
      if (state == DONE) begin
        word_cnt      <= '0;
        event_count_o <= event_count_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_event_reader.sv
// Testbench for event_reader: a queue-based FIFO model feeds the DUT and a
// scoreboard of expected beats (built when words are pushed) checks the stream.
module tb_event_reader;

  localparam int W = 16;
`ifdef EVENT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int BEATS = W + HDR;
  localparam logic [31:0] MAGIC = 32'h4D554F4E;

  typedef struct {
    int n_events;
    int ready_mode;
    int data_mode;
    int exp_beats;
    int exp_rd;
    int exp_sent;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        event_sent;
  logic [31:0] event_count;

  event_reader_if #(.COUNT_WIDTH(16)) bus ();

  event_reader #(
    .WORDS_PER_EVENT(W),
    .COUNT_WIDTH(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .event_sent_o (event_sent),
    .event_count_o(event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] fifo[$];
  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          beats = 0;
  int          rd_pulses = 0;
  int          sent_pulses = 0;
  int          ready_mode = 0;
  logic        pop_req = 1'b0;
  logic        count_force = 1'b0;
  logic [15:0] count_val = '0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic [31:0] model_events = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s", name);
  endtask

  // Reference model: an event is its words in push order, last flag on word W-1,
  // preceded by a header carrying the number of events completed before it.
  task automatic pushEvent(input int data_mode);
    logic [63:0] word;
`ifdef EVENT_HEADER_EN
    exp_q.push_back('{data: {MAGIC, model_events}, last: 1'b0});
`endif
    for (int i = 0; i < W; i++) begin
      word = (data_mode == 0) ? 64'(i) : {$urandom, $urandom};
      fifo.push_back(word);
      exp_q.push_back('{data: word, last: (i == W - 1)});
    end
    model_events = model_events + 32'd1;
  endtask

  task automatic monitor();
    beat_t b;
    if (prev_hold) begin
      checkOutput("hold_valid", 64'(bus.m_axis_tvalid), 64'd1);
      checkOutput("hold_data", bus.m_axis_tdata, prev_data);
      checkOutput("hold_last", 64'(bus.m_axis_tlast), 64'(prev_last));
    end
    if (bus.m_axis_tlast) begin
      checkOutput("last_needs_valid", 64'(bus.m_axis_tvalid), 64'd1);
    end
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      beats++;
      if (exp_q.size() == 0) begin
        failNow("unexpected_beat");
      end else begin
        b = exp_q.pop_front();
        checkOutput("beat_data", bus.m_axis_tdata, b.data);
        checkOutput("beat_last", 64'(bus.m_axis_tlast), 64'(b.last));
      end
    end
    if (bus.rd_en_o) begin
      rd_pulses++;
      checkOutput("rd_en_while_empty", 64'(bus.empty_i), 64'd0);
    end
    if (event_sent) sent_pulses++;
    pop_req   = bus.rd_en_o;
    prev_hold = bus.m_axis_tvalid && !bus.m_axis_tready;
    prev_data = bus.m_axis_tdata;
    prev_last = bus.m_axis_tlast;
  endtask

  // One clock: FIFO pops and inputs change just after the rising edge, outputs are checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_req && fifo.size() > 0) bus.dout_i = fifo.pop_front();
    bus.empty_i    = (fifo.size() == 0);
    bus.rd_count_i = count_force ? count_val : 16'(fifo.size());
    case (ready_mode)
      0:       bus.m_axis_tready = 1'b1;
      1:       bus.m_axis_tready = ~bus.m_axis_tready;
      default: bus.m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk);
    monitor();
  endtask

  task automatic waitSent(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (sent_pulses < target && k < budget) begin
      tick();
      k++;
    end
    if (sent_pulses < target) failNow(name);
  endtask

  task automatic applyStimulus(input vec_t v);
    int b0;
    int r0;
    int s0;
    ready_mode = v.ready_mode;
    b0 = beats;
    r0 = rd_pulses;
    s0 = sent_pulses;
    for (int e = 0; e < v.n_events; e++) pushEvent(v.data_mode);
    waitSent(s0 + v.n_events, 200 * W * v.n_events, "vec_timeout");
    repeat (3) tick();
    checkOutput("vec_beats", 64'(beats - b0), 64'(v.exp_beats));
    checkOutput("vec_rd_pulses", 64'(rd_pulses - r0), 64'(v.exp_rd));
    checkOutput("vec_sent_pulses", 64'(sent_pulses - s0), 64'(v.exp_sent));
    checkOutput("vec_pending_beats", 64'(exp_q.size()), 64'd0);
    checkOutput("vec_event_count", 64'(event_count), 64'(model_events));
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_tvalid"}, 64'(bus.m_axis_tvalid), 64'd0);
    checkOutput({tag, "_tlast"}, 64'(bus.m_axis_tlast), 64'd0);
    checkOutput({tag, "_rd_en"}, 64'(bus.rd_en_o), 64'd0);
    checkOutput({tag, "_event_sent"}, 64'(event_sent), 64'd0);
    checkOutput({tag, "_event_count"}, 64'(event_count), 64'd0);
    checkOutput({tag, "_tdata"}, bus.m_axis_tdata, 64'd0);
  endtask

  // Main sequence: reset, vector table, then hand-written corner cases.
  initial begin
    vec_t vecs[6];
    vec_t one_event;
    int   n;
    int   b0;
    int   r0;
    int   s0;
    logic seen_valid;

    vecs[0] = '{1, 0, 0, BEATS, W, 1};
    vecs[1] = '{1, 1, 0, BEATS, W, 1};
    vecs[2] = '{2, 2, 1, 2 * BEATS, 2 * W, 2};
    vecs[3] = '{1, 2, 1, BEATS, W, 1};
    vecs[4] = '{3, 0, 1, 3 * BEATS, 3 * W, 3};
    vecs[5] = '{2, 1, 1, 2 * BEATS, 2 * W, 2};
    one_event = '{1, 0, 0, BEATS, W, 1};

    reset             = 1'b1;
    bus.empty_i       = 1'b1;
    bus.rd_count_i    = '0;
    bus.dout_i        = '0;
    bus.m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Below-threshold count must not start an event; reaching it starts one after a fixed latency.
    ready_mode  = 0;
    count_force = 1'b1;
    count_val   = 16'd15;
    pushEvent(0);
    r0 = rd_pulses;
    s0 = sent_pulses;
    seen_valid = 1'b0;
    repeat (100) begin
      tick();
      if (bus.m_axis_tvalid) seen_valid = 1'b1;
    end
    checkOutput("below_threshold_rd_en", 64'(rd_pulses - r0), 64'd0);
    checkOutput("below_threshold_tvalid", 64'(seen_valid), 64'd0);
    count_val = 16'd16;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.m_axis_tvalid && n < 20);
    checkOutput("start_latency_edges", 64'(n - 1), 64'((HDR != 0) ? 1 : 3));
    count_force = 1'b0;
    waitSent(s0 + 1, 200 * W, "latency_event_timeout");
    repeat (3) tick();
    checkOutput("latency_pending_beats", 64'(exp_q.size()), 64'd0);
    checkOutput("latency_event_count", 64'(event_count), 64'(model_events));

    // Reset after the 7th handshake abandons the event without a read or tlast.
    ready_mode = 0;
    pushEvent(0);
    b0 = beats;
    n = 0;
    while (beats - b0 < 7 && n < 2000) begin
      tick();
      n++;
    end
    if (beats - b0 < 7) failNow("seventh_beat_timeout");
    tick();
    reset = 1'b1;
    #1;
    checkOutput("no_read_in_reset", 64'(bus.rd_en_o), 64'd0);
    pop_req = bus.rd_en_o;
    tick();
    checkIdleOutputs("mid_reset");
    fifo.delete();
    exp_q.delete();
    model_events = '0;
    prev_hold    = 1'b0;
    reset        = 1'b0;
    applyStimulus(one_event);

    // Event counter wraps from all-ones to zero.
    force dut.event_count_o = 32'hFFFF_FFFF;
    tick();
    release dut.event_count_o;
    #1;
    checkOutput("forced_count", 64'(event_count), 64'h0000_0000_FFFF_FFFF);
    model_events = 32'hFFFF_FFFF;
    applyStimulus(vecs[3]);
    checkOutput("count_wrap", 64'(event_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/event_reader.md
EVENT_READER -- requirements
Module: event_reader

Interface
REQ-001 The block SHALL have parameter WORDS_PER_EVENT, default 16, giving the number of 64-bit data words per event.
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 16, giving the width of the FIFO read-count input.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port empty_i, input, 1 bit: event FIFO empty flag.
REQ-006 The block SHALL have port rd_count_i, input, COUNT_WIDTH bits: number of words in the event FIFO.
REQ-007 The block SHALL have port dout_i, input, 64 bits: FIFO read data, valid one cycle after rd_en_o.
REQ-008 The block SHALL have port rd_en_o, output, 1 bit: FIFO read strobe.
REQ-009 The block SHALL have port m_axis_tdata, output, 64 bits: stream data.
REQ-010 The block SHALL have port m_axis_tvalid, output, 1 bit: stream valid.
REQ-011 The block SHALL have port m_axis_tready, input, 1 bit: stream ready.
REQ-012 The block SHALL have port m_axis_tlast, output, 1 bit: last word of event.
REQ-013 The block SHALL have port event_sent_o, output, 1 bit: one-cycle pulse per completed event.
REQ-014 The block SHALL have port event_count_o, output, 32 bits: completed-event counter.

Function
REQ-015 The FSM SHALL have states IDLE, HEADER, READ, LATCH, SEND and DONE.
REQ-016 In IDLE, when rd_count_i >= WORDS_PER_EVENT, the FSM SHALL go next cycle to HEADER if EVENT_HEADER_EN is defined, else to READ; otherwise it SHALL stay in IDLE.
REQ-017 In READ, rd_en_o SHALL be 1 for exactly one cycle and the FSM SHALL go to LATCH, but only if empty_i=0.
REQ-018 In READ with empty_i=1, rd_en_o SHALL stay 0 and the FSM SHALL stay in READ; rd_en_o SHALL never be 1 while empty_i=1.
REQ-019 In LATCH, dout_i SHALL be registered into m_axis_tdata and the FSM SHALL go to SEND.
REQ-020 In SEND, m_axis_tvalid SHALL be 1, and m_axis_tdata and m_axis_tlast SHALL be held stable until m_axis_tready=1.
REQ-021 m_axis_tlast SHALL be 1 only in SEND with word counter = WORDS_PER_EVENT-1.
REQ-022 On a SEND handshake (tvalid and tready both 1):
- if word counter = WORDS_PER_EVENT-1, the FSM SHALL go to DONE;
- else the word counter SHALL increment and the FSM SHALL go to READ.
REQ-023 In DONE, event_sent_o SHALL be 1 for one cycle, event_count_o SHALL increment by 1 (wrapping 0xFFFFFFFF->0), the word counter SHALL clear, and the FSM SHALL go to IDLE.
REQ-024 The word counter SHALL be $clog2(WORDS_PER_EVENT) bits wide and SHALL never exceed WORDS_PER_EVENT-1.
REQ-025 m_axis_tvalid SHALL be 0 in every state except HEADER and SEND.
REQ-026 Latency SHALL be 3 cycles from IDLE (condition true) to the first data tvalid without a header (IDLE->READ->LATCH->SEND), with a minimum of 3 cycles per data word.
REQ-027 Words SHALL be emitted in FIFO order, word 0 first, with no word dropped or duplicated under any m_axis_tready pattern.
REQ-028 A new event SHALL NOT start before DONE of the previous event; rd_count_i changes mid-event SHALL be ignored.

Reset
REQ-029 With reset=1 at a clk edge, the FSM SHALL go to IDLE and the word counter, event_count_o, m_axis_tdata, m_axis_tvalid, m_axis_tlast, rd_en_o and event_sent_o SHALL all be 0.
REQ-030 Reset mid-event SHALL abandon the partial event without emitting tlast, and SHALL NOT issue a further FIFO read.

Configuration
REQ-031 With macro EVENT_HEADER_EN defined:
- HEADER SHALL drive m_axis_tdata = {32'h4D554F4E, event_count_o}, m_axis_tvalid=1, m_axis_tlast=0;
- on handshake the FSM SHALL go to READ;
- each event SHALL be WORDS_PER_EVENT+1 beats.
REQ-032 Without EVENT_HEADER_EN, the HEADER state SHALL be unreachable and each event SHALL be exactly WORDS_PER_EVENT beats.

Verification
REQ-033 FIFO preloaded with 16 words 0x0..0xF, rd_count_i=16, tready=1 -> 16 beats, data 0x0..0xF, tlast only on 0xF, then one event_sent_o pulse and event_count_o=1.
REQ-034 Same stimulus with tready toggling 1/0 every cycle -> identical data sequence, tdata stable while tvalid=1 and tready=0, exactly 16 rd_en_o pulses.
REQ-035 rd_count_i=15 held for 100 cycles -> rd_en_o stays 0 and tvalid stays 0; rd_count_i raised to 16 -> first tvalid exactly 3 cycles later.
REQ-036 reset=1 asserted after the 7th handshake -> all outputs 0 next cycle, no tlast, event_count_o=0; a fresh 16-word event then streams correctly.
REQ-037 EVENT_HEADER_EN defined, two back-to-back events -> first beats 0x4D554F4E_00000000 and 0x4D554F4E_00000001, 17 beats each.
REQ-038 event_count_o forced to 0xFFFFFFFF and one event sent -> event_count_o=0x00000000.
